// File: rtl/banco_pkg.sv
`default_nettype none
// ============================================================================
// Module : banco_pkg
// Brief  : Shared defaults and clear-FSM state encoding for the register bank.
// Rev    : 1.0  initial release
// ============================================================================
package banco_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/banco_rd_port.sv
`default_nettype none
// ============================================================================
// Module : banco_rd_port
// Brief  : One read port: word select, zero register, write bypass, optional output register.
// Rev    : 1.0  initial release
// ============================================================================
module banco_rd_port
    import banco_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem [1<<ADDR_W],
    input  logic              wr_fwd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] rd_q;

    always_comb begin
        value = mem[addr];
        if ((ZERO_REG != 0) && (addr == '0)) begin
            value = '0;
        end else if ((BYPASS != 0) && wr_fwd && (wr_addr == addr)) begin
            value = wr_data;
        end
    end

    // The register is pruned by synthesis when READ_LAT selects the combinational path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= value;
        end
    end

    assign rd_data = (READ_LAT != 0) ? rd_q : value;

endmodule
`default_nettype wire

// File: rtl/banco_r_param.sv
`default_nettype none
// ============================================================================
// Module : banco_r_param
// Brief  : Parametrised 2R/1W register file with bypass, registered reads and bulk clear.
// Rev    : 1.0  initial release
// ============================================================================
module banco_r_param
    import banco_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] AddrR1,
    input  logic [ADDR_W-1:0] AddrR2,
    input  logic [ADDR_W-1:0] AddrW,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              W_R,
    input  logic              clr_req,
    output logic [DATA_W-1:0] RX,
    output logic [DATA_W-1:0] RY,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] clr_ptr;
    state_t            state;
    state_t            state_nxt;
    logic              wr_fwd;
    logic              wr_keep;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
            CLEAR:   if (clr_ptr == LAST_ADDR) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == CLEAR);
    end

    assign wr_fwd  = W_R && !busy;
    assign wr_keep = wr_fwd && !((ZERO_REG != 0) && (AddrW == '0));

    // The clear sweep owns the array; writes arriving meanwhile are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
            clr_ptr      <= clr_ptr + 1'b1;
        end else if (wr_keep) begin
            mem[AddrW] <= DataIn;
        end
    end

    banco_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS),
        .READ_LAT (READ_LAT)
    ) u_port_x (
        .clk     (clk),
        .reset   (reset),
        .addr    (AddrR1),
        .mem     (mem),
        .wr_fwd  (wr_fwd),
        .wr_addr (AddrW),
        .wr_data (DataIn),
        .rd_data (RX)
    );

    banco_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS),
        .READ_LAT (READ_LAT)
    ) u_port_y (
        .clk     (clk),
        .reset   (reset),
        .addr    (AddrR2),
        .mem     (mem),
        .wr_fwd  (wr_fwd),
        .wr_addr (AddrW),
        .wr_data (DataIn),
        .rd_data (RY)
    );

endmodule
`default_nettype wire
